// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses inst_mem and presents one
// registered fetch slot to decode under a valid/ready handshake.
module fetch_unit #(
   parameter int unsigned           MEM_SIZE   = 1024,
   parameter logic [31:0]           RESET_PC   = 32'h0,
   parameter int unsigned           INST_WIDTH = 32,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h0000_0013)
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   output logic [$clog2(MEM_SIZE)-1:0]     o_imem_addr,
   input  logic [INST_WIDTH-1:0]           i_imem_inst,
   input  logic                            i_redirect_valid,
   input  logic [31:0]                     i_redirect_pc,
   output logic                            o_fetch_valid,
   input  logic                            i_fetch_ready,
   output logic [31:0]                     o_fetch_pc,
   output logic [INST_WIDTH-1:0]           o_fetch_inst,
   output logic                            o_fetch_misaligned
);

   localparam int unsigned ADDR_W = $clog2(MEM_SIZE);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_FAULT
   } state_e;

   state_e                state_q, state_d;
   logic [31:0]           pc_q, pc_d;
   logic                  valid_q, valid_d;
   logic [31:0]           slot_pc_q, slot_pc_d;
   logic [INST_WIDTH-1:0] slot_inst_q, slot_inst_d;
   logic                  slot_mis_q, slot_mis_d;

   logic slot_free;
   logic redirect_mis;

   assign slot_free    = !valid_q || i_fetch_ready;
   assign redirect_mis = |i_redirect_pc[1:0];

   // NOTE: every next-state signal takes its held value first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      valid_d     = valid_q;
      slot_pc_d   = slot_pc_q;
      slot_inst_d = slot_inst_q;
      slot_mis_d  = slot_mis_q;

      if (i_redirect_valid) begin
         // Redirect wins over stall and handshake; a slot accepted this cycle is simply gone.
         pc_d = i_redirect_pc;
         if (redirect_mis) begin
            state_d     = ST_FAULT;
            valid_d     = 1'b1;
            slot_pc_d   = i_redirect_pc;
            slot_inst_d = NOP_INST;
            slot_mis_d  = 1'b1;
         end else begin
            state_d = ST_RUN;
            valid_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            ST_BOOT: begin
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (slot_free) begin
                  valid_d     = 1'b1;
                  slot_pc_d   = pc_q;
                  slot_inst_d = i_imem_inst;
                  slot_mis_d  = 1'b0;
                  pc_d        = pc_q + 32'd4;
               end
            end
            ST_FAULT: begin
               if (valid_q && i_fetch_ready) begin
                  valid_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_BOOT;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         valid_q     <= 1'b0;
         slot_pc_q   <= 32'h0;
         slot_inst_q <= '0;
         slot_mis_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         valid_q     <= valid_d;
         slot_pc_q   <= slot_pc_d;
         slot_inst_q <= slot_inst_d;
         slot_mis_q  <= slot_mis_d;
      end
   end

   assign o_imem_addr        = pc_q[ADDR_W-1:0];
   assign o_fetch_valid      = valid_q;
   assign o_fetch_pc         = slot_pc_q;
   assign o_fetch_inst       = slot_inst_q;
   assign o_fetch_misaligned = slot_mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random ready and
// redirect traffic, scored against an expected-slot stream derived from the PC rules.
module tb_fetch_unit;

   localparam int unsigned MEM_SIZE = 1024;
   localparam int unsigned ADDR_W   = 10;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          STREAM_N = 64;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_inst;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              fetch_valid;
   logic              fetch_ready;
   logic [31:0]       fetch_pc;
   logic [31:0]       fetch_inst;
   logic              fetch_mis;

   logic [31:0] mem [256];
   exp_t        exp_q [$];

   int n_checks = 0;
   int n_errors = 0;
   int accepted = 0;

   logic        hold_prev = 1'b0;
   logic [31:0] prev_pc;
   logic [31:0] prev_inst;
   logic        prev_mis;

   fetch_unit #(
      .MEM_SIZE (MEM_SIZE),
      .RESET_PC (RESET_PC)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .o_imem_addr        (imem_addr),
      .i_imem_inst        (imem_inst),
      .i_redirect_valid   (redirect_valid),
      .i_redirect_pc      (redirect_pc),
      .o_fetch_valid      (fetch_valid),
      .i_fetch_ready      (fetch_ready),
      .o_fetch_pc         (fetch_pc),
      .o_fetch_inst       (fetch_inst),
      .o_fetch_misaligned (fetch_mis)
   );

   // Combinational instruction memory model.
   assign imem_inst = mem[imem_addr[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_at(input logic [31:0] pc);
      return mem[pc[9:2]];
   endfunction

   // Expected slot stream after a redirect or reset: sequential words from the
   // target, or a single fault entry when the target is misaligned.
   task automatic push_stream(input logic [31:0] target);
      exp_t e;
      exp_q.delete();
      if (target[1:0] != 2'b00) begin
         e.pc   = target;
         e.inst = NOP;
         e.mis  = 1'b1;
         exp_q.push_back(e);
      end else begin
         for (int k = 0; k < STREAM_N; k++) begin
            e.pc   = target + 32'(4 * k);
            e.inst = mem_at(e.pc);
            e.mis  = 1'b0;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Called just after a rising edge; updates the scoreboard after the monitor
   // has scored any handshake of this same cycle.
   task automatic do_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(negedge clk);
      #1;
      push_stream(target);
   endtask

   task automatic chk_slot(input string name, input logic [31:0] pc, input logic [31:0] inst,
                           input logic mis);
      check({name, "_valid"}, 64'(fetch_valid), 64'(1'b1));
      check({name, "_pc"},    64'(fetch_pc),    64'(pc));
      check({name, "_inst"},  64'(fetch_inst),  64'(inst));
      check({name, "_mis"},   64'(fetch_mis),   64'(mis));
   endtask

   always @(negedge rst_n) hold_prev = 1'b0;

   // Monitor: scores every handshake and checks slot stability under back-pressure.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_prev) begin
            check("stable_valid", 64'(fetch_valid), 64'(1'b1));
            check("stable_pc",    64'(fetch_pc),    64'(prev_pc));
            check("stable_inst",  64'(fetch_inst),  64'(prev_inst));
            check("stable_mis",   64'(fetch_mis),   64'(prev_mis));
         end
         hold_prev = fetch_valid && !fetch_ready && !redirect_valid;
         prev_pc   = fetch_pc;
         prev_inst = fetch_inst;
         prev_mis  = fetch_mis;

         if (fetch_valid && fetch_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_unexpected: got slot pc=%0h, expected no slot (t=%0t)",
                        fetch_pc, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_pc",   64'(fetch_pc),   64'(e.pc));
               check("sb_inst", 64'(fetch_inst), 64'(e.inst));
               check("sb_mis",  64'(fetch_mis),  64'(e.mis));
            end
         end
      end
   end

   initial begin
      logic [31:0] target;
      int          since;
      int          r;

      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h11;
      mem[1] = 32'h22;
      mem[2] = 32'h33;
      mem[3] = 32'h44;

      rst_n          = 1'b0;
      fetch_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Reset state.
      #12;
      check("rst_valid", 64'(fetch_valid), 64'(1'b0));
      check("rst_pc",    64'(fetch_pc),    64'h0);
      check("rst_inst",  64'(fetch_inst),  64'h0);
      check("rst_mis",   64'(fetch_mis),   64'(1'b0));
      check("rst_addr",  64'(imem_addr),   64'(RESET_PC[9:0]));
      @(negedge clk);
      #1;
      push_stream(RESET_PC);
      rst_n = 1'b1;

      // Boot, then one slot per cycle.
      cyc(); smp();
      check("boot_valid", 64'(fetch_valid), 64'(1'b0));
      check("boot_addr",  64'(imem_addr),   64'h0);
      cyc(); smp();
      chk_slot("t1_s0", 32'h0, 32'h11, 1'b0);
      check("t1_addr4", 64'(imem_addr), 64'h4);

      // Back-pressure holds the slot and the address.
      cyc();
      fetch_ready = 1'b0;
      smp();
      chk_slot("t1_s1", 32'h4, 32'h22, 1'b0);
      check("t1_addr8", 64'(imem_addr), 64'h8);
      for (int i = 0; i < 3; i++) begin
         cyc(); smp();
         chk_slot("t2_hold", 32'h4, 32'h22, 1'b0);
         check("t2_hold_addr", 64'(imem_addr), 64'h8);
      end
      cyc();
      fetch_ready = 1'b1;
      smp();
      cyc(); smp();
      chk_slot("t2_next", 32'h8, 32'h33, 1'b0);
      check("t2_addrc", 64'(imem_addr), 64'hc);

      // Aligned redirect while stalled.
      cyc();
      fetch_ready = 1'b0;
      do_redirect(32'h100);
      cyc(); smp();
      check("t3_flush_valid", 64'(fetch_valid), 64'(1'b0));
      check("t3_addr", 64'(imem_addr), 64'h100);
      cyc(); smp();
      chk_slot("t3_slot", 32'h100, mem_at(32'h100), 1'b0);

      // Misaligned redirect, fault slot, recovery.
      cyc();
      do_redirect(32'h102);
      cyc(); smp();
      chk_slot("t4_fault", 32'h102, NOP, 1'b1);
      cyc(); smp();
      chk_slot("t4_fault_hold", 32'h102, NOP, 1'b1);
      cyc();
      fetch_ready = 1'b1;
      smp();
      cyc(); smp();
      check("t4_after_accept", 64'(fetch_valid), 64'(1'b0));
      cyc(); smp();
      check("t4_no_fetch", 64'(fetch_valid), 64'(1'b0));
      cyc();
      do_redirect(32'h20);
      cyc(); smp();
      check("t4_rec_valid", 64'(fetch_valid), 64'(1'b0));
      check("t4_rec_addr", 64'(imem_addr), 64'h20);
      cyc(); smp();
      chk_slot("t4_rec_slot", 32'h20, mem_at(32'h20), 1'b0);

      // Address wrap at the top of the memory.
      cyc();
      do_redirect(32'h3fc);
      cyc(); smp();
      check("t5_addr3fc", 64'(imem_addr), 64'h3fc);
      cyc(); smp();
      chk_slot("t5_top", 32'h3fc, mem_at(32'h3fc), 1'b0);
      check("t5_wrap_addr", 64'(imem_addr), 64'h0);
      cyc(); smp();
      chk_slot("t5_over", 32'h400, mem[0], 1'b0);

      // Asynchronous reset mid-stream.
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid", 64'(fetch_valid), 64'(1'b0));
      check("t6_addr",  64'(imem_addr),   64'(RESET_PC[9:0]));
      exp_q.delete();
      @(negedge clk);
      #1;
      push_stream(RESET_PC);
      rst_n = 1'b1;
      cyc(); smp();
      check("t6_boot_valid", 64'(fetch_valid), 64'(1'b0));
      cyc(); smp();
      chk_slot("t6_restart", 32'h0, 32'h11, 1'b0);

      // Random traffic.
      since = 0;
      for (int c = 0; c < 2000; c++) begin
         cyc();
         fetch_ready = ($urandom_range(0, 3) != 0);
         since++;
         if (since >= 48 || $urandom_range(0, 24) == 0) begin
            r = $urandom_range(0, 9);
            if (r < 6)       target = $urandom & 32'hFFFF_FFFC;
            else if (r < 8)  target = $urandom | 32'h1;
            else if (r == 8) target = 32'hFFFF_FFF8;
            else             target = 32'h0000_03F0;
            do_redirect(target);
            since = 0;
         end
      end
      cyc(); smp();

      check("accept_count_min", 64'(accepted >= 200), 64'(1'b1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
